// File: rtl/ling64_addsub_pipe.sv
// 64-bit add/subtract on a Ling pseudo-carry prefix network, three registered stages
// with valid/ready flow control and a 2-flop reset release.
module ling64_addsub_pipe #(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_res,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  if (LATENCY != 3) begin : g_bad_latency
    $error("ling64_addsub_pipe: LATENCY must be 3");
  end

  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // Stage 1 inputs: generate/transmit/xor with cin folded into bit 0, then the
  // first span-1 prefix level. Ling element i pairs g[i] with t[i-1].
  logic [63:0] b_eff, g_v, t_v, lt_v;
  logic [63:0] x_d, t_d, r2_d, q2_d;

  always_comb begin
    b_eff    = in_sub ? ~in_b : in_b;
    g_v      = in_a & b_eff;
    t_v      = in_a | b_eff;
    x_d      = in_a ^ b_eff;
    g_v[0]   = g_v[0] | (t_v[0] & in_sub);
    x_d[0]   = x_d[0] ^ in_sub;
    t_d      = t_v;
    lt_v     = {t_v[62:0], 1'b0};
    r2_d     = g_v | (lt_v & {g_v[62:0], 1'b0});
    q2_d     = lt_v & {lt_v[62:0], 1'b0};
  end

  logic             v1_q, v2_q, v3_q;
  logic [63:0]      x1_q, t1_q, r2_q, q2_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic             a63_1_q, b63_1_q;

  // Stage 2 inputs: remaining Kogge-Stone levels give the full Ling H vector.
  logic [63:0] gg, tt, ng, nt;
  logic [63:0] r4_d, xd_d;

  always_comb begin
    gg = r2_q;
    tt = q2_q;
    ng = '0;
    nt = '0;
    for (int unsigned s = 2; s < 64; s = s * 2) begin
      ng = gg;
      nt = tt;
      for (int unsigned i = s; i < 64; i++) begin
        ng[i] = gg[i] | (tt[i] & gg[i-s]);
        nt[i] = tt[i] & tt[i-s];
      end
      gg = ng;
      tt = nt;
    end
    r4_d = gg;
    xd_d = x1_q ^ {t1_q[62:0], 1'b0};
  end

  logic [63:0] h2_q, xd2_q, x2_q;
  logic        a63_2_q, b63_2_q, t63_2_q;

  // Stage 3 inputs: H[i-1] selects the pre-carried sum bit.
  logic [63:0] sel_v, res_d;
  logic        cout_d, ovf_d, zero_d;

  always_comb begin
    sel_v  = {h2_q[62:0], 1'b0};
    res_d  = (sel_v & xd2_q) | (~sel_v & x2_q);
    cout_d = t63_2_q & h2_q[63];
    ovf_d  = (a63_2_q == b63_2_q) & (res_d[63] != a63_2_q);
    zero_d = (res_d == '0);
  end

  logic [63:0] res_q;
  logic        cout_q, ovf_q, zero_q;
  logic        en1, en2, en3;

  assign en3      = ~v3_q | out_ready;
  assign en2      = ~v2_q | en3;
  assign en1      = ~v1_q | en2;
  assign in_ready = rst_int_n & en1;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      x1_q <= '0; t1_q <= '0; r2_q <= '0; q2_q <= '0;
      tag1_q <= '0; tag2_q <= '0; tag3_q <= '0;
      a63_1_q <= 1'b0; b63_1_q <= 1'b0;
      h2_q <= '0; xd2_q <= '0; x2_q <= '0;
      a63_2_q <= 1'b0; b63_2_q <= 1'b0; t63_2_q <= 1'b0;
      res_q <= '0; cout_q <= 1'b0; ovf_q <= 1'b0; zero_q <= 1'b0;
    end else begin
      if (en1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          x1_q    <= x_d;
          t1_q    <= t_d;
          r2_q    <= r2_d;
          q2_q    <= q2_d;
          tag1_q  <= in_tag;
          a63_1_q <= in_a[63];
          b63_1_q <= b_eff[63];
        end
      end
      if (en2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          h2_q    <= r4_d;
          xd2_q   <= xd_d;
          x2_q    <= x1_q;
          a63_2_q <= a63_1_q;
          b63_2_q <= b63_1_q;
          t63_2_q <= t1_q[63];
          tag2_q  <= tag1_q;
        end
      end
      if (en3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          res_q  <= res_d;
          cout_q <= cout_d;
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
          tag3_q <= tag2_q;
        end
      end
    end
  end

  assign out_valid = v3_q;
  assign out_res   = res_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_ling64_addsub_pipe.sv
// Scoreboard bench for ling64_addsub_pipe: arithmetic reference model, directed corner
// cases, backpressure, mid-flight reset and randomized traffic.
module tb_ling64_addsub_pipe;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sub = 1'b0;
  logic [63:0]   in_a = '0;
  logic [63:0]   in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_res;
  logic          out_cout, out_ovf, out_zero;
  logic [TW-1:0] out_tag;

  ling64_addsub_pipe #(.TAG_W(TW), .LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sub(in_sub), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]   res;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input logic [TW-1:0] tag);
    exp_t        e;
    logic [64:0] w;
    if (sub) begin
      w[63:0] = a - b;
      w[64]   = (a >= b);
    end else begin
      w = {1'b0, a} + {1'b0, b};
    end
    e.res  = w[63:0];
    e.cout = w[64];
    if (sub) e.ovf = (a[63] != b[63]) && (e.res[63] != a[63]);
    else     e.ovf = (a[63] == b[63]) && (e.res[63] != a[63]);
    e.zero = (e.res == 64'd0);
    e.tag  = tag;
    return e;
  endfunction

  // Monitor: samples mid-cycle, pushes accepted beats, pops/compares drained beats.
  exp_t held;
  logic hold_valid = 1'b0;
  always @(negedge clk) begin
    exp_t cur, e;
    cur = {out_res, out_cout, out_ovf, out_zero, out_tag};
    if (!rst_n) begin
      sb.delete();
      hold_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (hold_valid) begin
          checks++;
          if (cur !== held) begin
            errors++;
            $display("FAIL hold: got %h required %h", cur, held);
          end
        end
        if (out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got %h required no output", cur);
          end else begin
            e = sb.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL result: got res=%h c=%b v=%b z=%b tag=%0d required res=%h c=%b v=%b z=%b tag=%0d",
                       out_res, out_cout, out_ovf, out_zero, out_tag, e.res, e.cout, e.ovf, e.zero, e.tag);
            end
          end
          hold_valid = 1'b0;
        end else begin
          held       = cur;
          hold_valid = 1'b1;
        end
      end else begin
        hold_valid = 1'b0;
      end
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_sub, in_tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Offers a beat until accepted; returns just after the accepting edge with in_valid still high.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub,
                      input logic [TW-1:0] tag);
    logic acc;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) break;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready=0 required 1");
        break;
      end
    end
  endtask

  task automatic directed(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic [TW-1:0] tag, input logic [63:0] eres,
                          input logic ecout, input logic eovf, input logic ezero);
    int k;
    send(a, b, sub, tag);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check({name, "_latency"}, 64'(k), 64'd3);
    @(negedge clk);
    check({name, "_res"}, out_res, eres);
    check({name, "_flags"}, {61'd0, out_cout, out_ovf, out_zero}, {61'd0, ecout, eovf, ezero});
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    step();
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: r = 64'd0;
      1: r = '1;
      2: r = 64'h8000_0000_0000_0000;
      3: r = 64'h7FFF_FFFF_FFFF_FFFF;
      4: r = 64'(r[3:0]);
      default: ;
    endcase
    return r;
  endfunction

  logic        rand_done = 1'b0;
  logic [63:0] bp_a [6];
  logic [63:0] bp_b [6];
  logic        bp_s [6];

  initial begin
    int acc, got_n;
    logic [TW-1:0] next_tag;

    repeat (3) step();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_out_res", out_res, 64'd0);
    check("reset_out_flags_tag", {57'd0, out_cout, out_ovf, out_zero, out_tag}, 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();

    directed("sub_5_3", 64'd5, 64'd3, 1'b1, 4'd1, 64'd2, 1'b1, 1'b0, 1'b0);
    directed("sub_wrap", 64'd0, 64'd1, 1'b1, 4'd2, '1, 1'b0, 1'b0, 1'b0);
    directed("sub_zero", 64'h1234, 64'h1234, 1'b1, 4'd3, 64'd0, 1'b1, 1'b0, 1'b1);
    directed("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 4'd4,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'd5,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0);
    directed("add_carry", '1, 64'd1, 1'b0, 4'd6, 64'd0, 1'b1, 1'b0, 1'b1);

    // Backpressure: only three beats fit while the consumer stalls.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = rnd_op(); bp_b[i] = rnd_op(); bp_s[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_a = bp_a[acc]; in_b = bp_b[acc]; in_sub = bp_s[acc]; in_tag = TW'(acc);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    check("bp_accepts", 64'(acc), 64'd3);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_tag_head", {63'd0, out_valid, 4'd0} | 64'(out_tag), {63'd1, 4'd0});
    out_ready = 1'b1;
    next_tag = '0;
    got_n = 0;
    fork
      begin
        for (int i = 3; i < 6; i++) send(bp_a[i], bp_b[i], bp_s[i], TW'(i));
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got_n < 6; c++) begin
          @(negedge clk);
          if (out_valid) begin
            check("bp_order_tag", 64'(out_tag), 64'(next_tag));
            next_tag++;
            got_n++;
          end
        end
        check("bp_drained", 64'(got_n), 64'd6);
      end
    join
    repeat (2) step();

    // Reset with two beats in flight.
    send(64'd100, 64'd7, 1'b0, 4'd9);
    send(64'd200, 64'd8, 1'b1, 4'd10);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_no_stale", 64'(out_valid), 64'd0);
      step();
    end
    directed("post_rst", 64'd10, 64'd4, 1'b1, 4'd11, 64'd6, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            step();
          end
          send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), TW'($urandom));
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          step();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int c = 0; c < 50 && (sb.size() != 0 || out_valid); c++) step();
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
